// File: rtl/ps2_pkg.sv
// Shared constants, state type and key decode helper for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Arrow keys (only meaningful after an E0 prefix)
  localparam logic [7:0] SC_ARR_UP    = 8'h75;
  localparam logic [7:0] SC_ARR_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARR_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARR_RIGHT = 8'h74;

  // WASD (plain codes, no prefix)
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_D = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Maps a scancode to a direction; DIR_NONE when unmapped or its keymap group is disabled.
  function automatic logic [2:0] key_to_dir(input logic [7:0] code, input logic ext,
                                            input logic [1:0] keymap);
    logic [2:0] d;
    d = DIR_NONE;
    if (keymap[0] && ext) begin
      case (code)
        SC_ARR_UP:    d = DIR_UP;
        SC_ARR_DOWN:  d = DIR_DOWN;
        SC_ARR_LEFT:  d = DIR_LEFT;
        SC_ARR_RIGHT: d = DIR_RIGHT;
        default:      d = DIR_NONE;
      endcase
    end else if (keymap[1] && !ext) begin
      case (code)
        SC_W:    d = DIR_UP;
        SC_S:    d = DIR_DOWN;
        SC_A:    d = DIR_LEFT;
        SC_D:    d = DIR_RIGHT;
        default: d = DIR_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// First-word fall-through FIFO for received scancodes.
// A push into a full FIFO is dropped (reported on drop) unless a pop happens in the same cycle.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Storage array; contents are don't-care until written, dout is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronisation, SCL glitch filter, frame deframer,
// E0/F0 prefix tracking, scancode FIFO and snake direction decode.
//
// state     | meaning
// ST_IDLE   | waiting for a filtered SCL falling edge with SDA=0 (start bit)
// ST_DATA   | shifting 8 data bits, LSB first
// ST_PARITY | waiting for the odd parity bit
// ST_STOP   | waiting for the stop bit; its edge triggers completion next clk
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int         FILTER_LEN  = 4,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [1:0] KEYMAP      = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCL,
  input  logic        SDA,
  output logic [7:0]  data_out,
  output logic [10:0] data_out_reg,
  output logic        data_valid,
  input  logic        data_ack,
  output logic [2:0]  direction,
  output logic        frame_err,
  output logic        overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic           scl_s1, scl_s2, sda_s1, sda_s2;
  logic           scl_f;
  logic [FCW-1:0] flt_cnt;
  logic           scl_fall;
  rx_state_t      state, state_nx;
  logic [2:0]     bit_cnt;
  logic [10:0]    shift_reg;
  logic [TCW-1:0] to_cnt;
  logic           timeout;
  logic           frame_done;
  logic           done_q;
  logic [7:0]     frame_byte;
  logic           frame_good;
  logic           is_prefix;
  logic           push;
  logic           fifo_drop;
  logic           ext, brk;
  logic [2:0]     dir_hit;

  // Two-flop synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
      sda_s1 <= SDA;
      sda_s2 <= sda_s1;
    end
  end

  // Filtered SCL only follows after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (scl_s2 != scl_f) begin
      if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FCW'(1);
      end
    end else begin
      flt_cnt <= '0;
    end
  end

  // Single-cycle strobe in the cycle the filtered SCL drops.
  assign scl_fall = scl_f && !scl_s2 && (flt_cnt == FCW'(FILTER_LEN - 1));
  assign timeout  = (state != ST_IDLE) && !scl_fall && (to_cnt == '0);

  // Deframer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Deframer next-state logic.
  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    if (timeout) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (scl_fall && !sda_s2) state_nx = ST_DATA;
        ST_DATA:   if (scl_fall && bit_cnt == 3'd7) state_nx = ST_PARITY;
        ST_PARITY: if (scl_fall) state_nx = ST_STOP;
        ST_STOP: begin
          if (scl_fall) begin
            state_nx   = ST_IDLE;
            frame_done = 1'b1;
          end
        end
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // Frame shift register, bit counter and inter-edge timeout down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      to_cnt    <= TCW'(TIMEOUT_CYC - 1);
      done_q    <= 1'b0;
    end else begin
      done_q <= frame_done;
      if (scl_fall && (state != ST_IDLE || !sda_s2))
        shift_reg <= {sda_s2, shift_reg[10:1]};
      if (state == ST_IDLE)
        bit_cnt <= '0;
      else if (state == ST_DATA && scl_fall)
        bit_cnt <= bit_cnt + 3'd1;
      if (state == ST_IDLE || scl_fall)
        to_cnt <= TCW'(TIMEOUT_CYC - 1);
      else if (to_cnt != '0)
        to_cnt <= to_cnt - TCW'(1);
    end
  end

  assign frame_byte = shift_reg[8:1];
  assign frame_good = (^shift_reg[9:1]) && shift_reg[10] && !shift_reg[0];
  assign is_prefix  = (frame_byte == SC_EXT) || (frame_byte == SC_BRK);
  assign push       = done_q && frame_good && !is_prefix;
  assign dir_hit    = key_to_dir(frame_byte, ext, KEYMAP);

  // Completion: raw frame capture, error pulse, prefix flags, direction and overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg <= '0;
      frame_err    <= 1'b0;
      ext          <= 1'b0;
      brk          <= 1'b0;
      direction    <= DIR_NONE;
      overflow     <= 1'b0;
    end else begin
      frame_err <= (done_q && !frame_good) || timeout;
      if (fifo_drop) overflow <= 1'b1;
      if (done_q) data_out_reg <= shift_reg;
      if (done_q && frame_good) begin
        if (frame_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (frame_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk && dir_hit != DIR_NONE) direction <= dir_hit;
        end
      end
    end
  end

  ps2_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (frame_byte),
    .pop   (data_ack),
    .dout  (data_out),
    .valid (data_valid),
    .drop  (fifo_drop)
  );

endmodule
